// File: rtl/ingress.sv
// ingress: serial-to-parallel input stage of a router port.
// Receives a framed serial packet (address, pad, payload), assembles the
// payload LSB-first into 32-bit words, tags each word with the packet address
// and an end-of-packet flag, and offers it to the port FIFO through a
// one-entry hold register that absorbs a single word of backpressure.
//
// Handshake: a word is transferred on every clock edge where push=1; push is
// hold_valid & ~full, so the FIFO accepts the word in the same cycle it sees
// push high and the hold register frees (or refills) on that edge.
module ingress #(
  parameter int ADDR_W     = 4,
  parameter int PAD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              din,
  input  logic              frame_n,
  input  logic              valid_n,
  input  logic              full,
  output logic [31:0]       dataout,
  output logic              push,
  output logic              last,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              drop,
  output logic              err,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_PAD     = 3'd2,
    S_DATA    = 3'd3,
    S_DISCARD = 3'd4
  } state_t;

  // Address bit 0 is taken in IDLE, so the ADDR state only counts the
  // remaining ADDR_W-1 bits (max count value ADDR_W-2).
  localparam int AC_W = (ADDR_W > 2) ? $clog2(ADDR_W - 1) : 1;
  localparam int PC_W = (PAD_CYCLES > 1) ? $clog2(PAD_CYCLES) : 1;

  state_t            state, state_nx;
  logic [AC_W-1:0]   addr_cnt;
  logic [PC_W-1:0]   pad_cnt;
  logic [4:0]        idx;
  logic [31:0]       shift;
  logic [ADDR_W-1:0] addr_sh;

  logic              hold_valid;
  logic [31:0]       hold_data;
  logic              hold_last;
  logic [ADDR_W-1:0] hold_addr;

  logic              addr_shift;
  logic              addr_inc;
  logic              pad_inc;
  logic              data_cap;
  logic              word_done;
  logic              err_set;
  logic [31:0]       cur_word;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state logic: packet framing and protocol-violation exits.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (!frame_n) state_nx = S_ADDR;
      S_ADDR: begin
        if (frame_n)                              state_nx = S_IDLE;
        else if (addr_cnt == AC_W'(ADDR_W - 2))   state_nx = S_PAD;
      end
      S_PAD: begin
        if (frame_n)                              state_nx = S_IDLE;
        else if (!valid_n)                        state_nx = S_DISCARD;
        else if (pad_cnt == PC_W'(PAD_CYCLES - 1)) state_nx = S_DATA;
      end
      S_DATA:    if (frame_n) state_nx = S_IDLE;
      S_DISCARD: if (frame_n) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Output/strobe logic: which datapath action happens on the coming edge.
  always_comb begin
    addr_shift = 1'b0;
    addr_inc   = 1'b0;
    pad_inc    = 1'b0;
    data_cap   = 1'b0;
    word_done  = 1'b0;
    err_set    = 1'b0;
    case (state)
      S_IDLE: addr_shift = !frame_n;
      S_ADDR: begin
        addr_shift = !frame_n;
        addr_inc   = !frame_n;
        err_set    = frame_n;
      end
      S_PAD: begin
        pad_inc = !frame_n && valid_n;
        err_set = frame_n || !valid_n;
      end
      S_DATA: begin
        data_cap  = !valid_n;
        word_done = !valid_n && (frame_n || (idx == 5'd31));
        err_set   = valid_n && frame_n;
      end
      default: ;
    endcase
  end

  // Word as it will look including the bit being sampled this cycle;
  // untouched upper bits stay zero because shift is cleared per word.
  always_comb begin
    cur_word      = shift;
    cur_word[idx] = din;
  end

  // Address / pad counters and the LSB-first address shifter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_cnt <= '0;
      pad_cnt  <= '0;
      addr_sh  <= '0;
    end else begin
      if (addr_shift) addr_sh <= {din, addr_sh[ADDR_W-1:1]};
      addr_cnt <= addr_inc ? addr_cnt + AC_W'(1) : '0;
      pad_cnt  <= pad_inc  ? pad_cnt  + PC_W'(1) : '0;
    end
  end

  // Payload assembly; cleared outside DATA so an aborted word never leaks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift <= '0;
      idx   <= '0;
    end else if (word_done || state != S_DATA) begin
      shift <= '0;
      idx   <= '0;
    end else if (data_cap) begin
      shift <= cur_word;
      idx   <= idx + 5'd1;
    end
  end

  assign push = hold_valid & ~full;

  // One-entry hold register: load on completion, free on push, drop if occupied.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_last  <= 1'b0;
      hold_addr  <= '0;
      drop       <= 1'b0;
    end else begin
      drop <= 1'b0;
      if (word_done) begin
        if (hold_valid && !push) begin
          drop <= 1'b1;
        end else begin
          hold_valid <= 1'b1;
          hold_data  <= cur_word;
          hold_last  <= frame_n;
          hold_addr  <= addr_sh;
        end
      end else if (push) begin
        hold_valid <= 1'b0;
      end
    end
  end

  // Registered protocol-error pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err <= 1'b0;
    else          err <= err_set;
  end

  assign dataout   = hold_data;
  assign last      = hold_last;
  assign addr      = hold_addr;
  assign busy      = (state != S_IDLE) || hold_valid;
  assign state_dbg = state;

endmodule
